// File: rtl/spi_minion_pkt_shifter.sv
// SPI minion physical layer: samples raw SPI pins, deserialises one packet per cs frame and
// serialises to_master onto miso. Define SPI_MINION_SHIFTER_SYNC_EN for two-flop pin synchronizers.
module spi_minion_pkt_shifter #(
    parameter int unsigned pack_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 serve,
    output logic                 hard_msg,
    output logic                 seize,
    output logic [pack_size-1:0] from_master,
    input  logic [pack_size-1:0] to_master
);

    localparam int unsigned CntW = $clog2(pack_size) + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(pack_size);
    localparam logic [CntW-1:0] CntSat  = CntW'(pack_size + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic cs_s_q, sclk_s_q, mosi_s_q;

`ifdef SPI_MINION_SHIFTER_SYNC_EN
    logic cs_meta_q, sclk_meta_q, mosi_meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_meta_q   <= 1'b1;
            sclk_meta_q <= 1'b1;
            mosi_meta_q <= 1'b0;
            cs_s_q      <= 1'b1;
            sclk_s_q    <= 1'b1;
            mosi_s_q    <= 1'b0;
        end else begin
            cs_meta_q   <= cs;
            sclk_meta_q <= sclk;
            mosi_meta_q <= mosi;
            cs_s_q      <= cs_meta_q;
            sclk_s_q    <= sclk_meta_q;
            mosi_s_q    <= mosi_meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_s_q   <= 1'b1;
            sclk_s_q <= 1'b1;
            mosi_s_q <= 1'b0;
        end else begin
            cs_s_q   <= cs;
            sclk_s_q <= sclk;
            mosi_s_q <= mosi;
        end
    end
`endif

    // Previous-level copies plus registered edge strobes; mosi is delayed to stay aligned with
    // the sclk_rise strobe it is captured on.
    logic cs_p_q, sclk_p_q;
    logic cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q, mosi_e_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_p_q      <= 1'b1;
            sclk_p_q    <= 1'b1;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            mosi_e_q    <= 1'b0;
        end else begin
            cs_p_q      <= cs_s_q;
            sclk_p_q    <= sclk_s_q;
            cs_fall_q   <= cs_p_q & ~cs_s_q;
            cs_rise_q   <= ~cs_p_q & cs_s_q;
            sclk_rise_q <= ~sclk_p_q & sclk_s_q;
            sclk_fall_q <= sclk_p_q & ~sclk_s_q;
            mosi_e_q    <= mosi_s_q;
        end
    end

    state_e               state_q;
    logic [pack_size-1:0] rx_q, tx_q, from_master_q;
    logic [CntW-1:0]      bit_cnt_q;
    logic                 serve_q, hard_msg_q, seize_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rx_q          <= '0;
            tx_q          <= '0;
            from_master_q <= '0;
            bit_cnt_q     <= '0;
            serve_q       <= 1'b0;
            hard_msg_q    <= 1'b0;
            seize_q       <= 1'b0;
        end else begin
            serve_q    <= 1'b0;
            hard_msg_q <= 1'b0;
            seize_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall_q) begin
                        tx_q      <= to_master;
                        seize_q   <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= StActive;
                    end
                end
                StActive: begin
                    // cs edges win over any sclk edge seen in the same cycle
                    if (cs_rise_q) begin
                        serve_q <= 1'b1;
                        state_q <= StIdle;
                        if (bit_cnt_q == CntFull) begin
                            from_master_q <= rx_q;
                        end else begin
                            hard_msg_q <= 1'b1;
                        end
                    end else if (!cs_fall_q) begin
                        if (sclk_rise_q) begin
                            rx_q <= {rx_q[pack_size-2:0], mosi_e_q};
                            if (bit_cnt_q != CntSat) begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else if (sclk_fall_q) begin
                            tx_q <= {tx_q[pack_size-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign miso        = tx_q[pack_size-1];
    assign serve       = serve_q;
    assign hard_msg    = hard_msg_q;
    assign seize       = seize_q;
    assign from_master = from_master_q;

endmodule

// File: tb/tb_spi_minion_pkt_shifter.sv
// Randomised scoreboard bench for spi_minion_pkt_shifter: frames of varying length, miso and
// serve/hard_msg/from_master checked by a monitor against a packet-level reference model.
module tb_spi_minion_pkt_shifter;

    localparam int unsigned P = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cs = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         miso, serve, hard_msg, seize;
    logic [P-1:0] from_master;
    logic [P-1:0] to_master = '0;

    spi_minion_pkt_shifter #(.pack_size(P)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .serve       (serve),
        .hard_msg    (hard_msg),
        .seize       (seize),
        .from_master (from_master),
        .to_master   (to_master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         hard;
        logic [P-1:0] fm;
    } exp_t;

    exp_t         sb_q[$];
    logic         exp_miso_q[$];
    logic [P-1:0] model_fm = '0;
    int           exp_seize = 0;
    logic         done = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    int   seize_cnt = 0;
    logic sclk_prev = 1'b0;

    // Sole checker: every comparison and both counters live here.
    always @(negedge clk) begin
        if (done) begin
            vectors++;
            if (sb_q.size() != 0) begin
                miscompares++;
                $display("FAIL serve_timeout: %0d frames never served, required 0", sb_q.size());
            end
            vectors++;
            if (exp_miso_q.size() != 0) begin
                miscompares++;
                $display("FAIL miso_bits_left: %0d bits unchecked, required 0", exp_miso_q.size());
            end
            vectors++;
            if (seize_cnt != exp_seize) begin
                miscompares++;
                $display("FAIL seize_count: got %0d, required %0d", seize_cnt, exp_seize);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end else if (!reset) begin
            vectors++;
            if ({miso, serve, hard_msg, seize} !== 4'b0 || from_master !== '0) begin
                miscompares++;
                $display("FAIL reset_state: miso=%b serve=%b hard_msg=%b seize=%b fm=%h, required 0",
                         miso, serve, hard_msg, seize, from_master);
            end
        end else begin
            if (seize) seize_cnt++;
            if (serve) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_serve: got serve=1, required no serve");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (hard_msg !== e.hard || (!e.hard && from_master !== e.fm) ||
                        (e.hard && from_master !== e.fm)) begin
                        miscompares++;
                        $display("FAIL frame_end: got hard_msg=%b fm=%h, required hard_msg=%b fm=%h",
                                 hard_msg, from_master, e.hard, e.fm);
                    end
                end
            end else begin
                vectors++;
                if (hard_msg !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hard_msg_idle: got %b without serve, required 0", hard_msg);
                end
            end
            if (sclk && !sclk_prev) begin
                vectors++;
                if (exp_miso_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL miso_extra: sclk rise with no expected bit, miso=%b", miso);
                end else begin
                    logic b;
                    b = exp_miso_q.pop_front();
                    if (miso !== b) begin
                        miscompares++;
                        $display("FAIL miso_bit: got %b, required %b", miso, b);
                    end
                end
            end
        end
        sclk_prev = sclk;
    end

    task automatic push_miso(input logic [P-1:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            exp_miso_q.push_back(i < int'(P) ? word[P-1-i] : 1'b0);
        end
    endtask

    task automatic clock_bits(input logic [P-1:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i < int'(P)) mosi = data[P-1-i];
            else mosi = 1'($urandom);
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [P-1:0] data, input int nbits, input logic [P-1:0] tx,
                         input int gap);
        exp_t e;
        exp_seize++;
        push_miso(tx, nbits);
        e.hard = (nbits != int'(P));
        if (!e.hard) model_fm = data;
        e.fm = model_fm;
        sb_q.push_back(e);
        to_master = tx;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        clock_bits(data, nbits);
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (6) @(negedge clk);

        frame(32'hDEADBEEF, 32, 32'hA5A5_0F0F, 10);
        frame(32'h1234_5678, 31, 32'h0F0F_F0F0, 10);
        frame(32'h8765_4321, 33, 32'hFFFF_0000, 10);
        frame(32'h0000_0001, 32, 32'h1357_9BDF, 4);
        frame(32'hFFFF_FFFF, 32, 32'h2468_ACE0, 10);
        frame(32'hCAFE_F00D, 0, 32'h8000_0001, 10);

        // Reset after 10 bits; cs stays low across release, so a fresh short frame follows.
        exp_seize++;
        to_master = 32'hC3C3_3C3C;
        push_miso(to_master, 10);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        clock_bits(32'($urandom), 10);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.delete();
        exp_miso_q.delete();
        model_fm = '0;
        to_master = 32'h5A5A_9669;
        push_miso(to_master, 22);
        e.hard = 1'b1;
        e.fm = '0;
        sb_q.push_back(e);
        exp_seize++;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (7) @(negedge clk);
        clock_bits(32'($urandom), 22);
        repeat (5) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            int nb;
            nb = ($urandom_range(0, 1) == 1) ? int'(P) : int'($urandom_range(0, P + 3));
            frame(32'($urandom), nb, 32'($urandom), int'($urandom_range(4, 12)));
        end

        repeat (30) @(negedge clk);
        done = 1'b1;
    end

endmodule

// File: doc/spi_minion_pkt_shifter.md
# spi_minion_pkt_shifter

SPI minion physical-layer stage that sits directly upstream of the SPI minion packet queue. Samples the raw SPI pins (cs, sclk, mosi) in the system clock domain, deserialises one `pack_size`-bit packet per chip-select frame into `from_master`, and serialises the queue's `to_master` word onto miso. Generates the queue's `serve`, `seize` and `hard_msg` controls: one `seize` pulse at frame start, one `serve` pulse at frame end, with `hard_msg` marking malformed frames.

## Interface
- `pack_size`, default 32: packet width in bits. Must be a multiple of 4 and at least 4.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous active-low reset; asserted when 0.
- `cs`  input  1  SPI chip select, active low, asynchronous to clk.
- `sclk`  input  1  SPI serial clock, asynchronous to clk.
- `mosi`  input  1  SPI data from master.
- `miso`  output  1  SPI data to master.
- `serve`  output  1  one-cycle pulse at frame end; drives the queue's enqueue.
- `hard_msg`  output  1  qualifies `serve`; 1 means drop the frame.
- `seize`  output  1  one-cycle pulse at frame start; drives the queue's dequeue.
- `from_master`  output  pack_size  last complete packet received.
- `to_master`  input  pack_size  packet to transmit, combinational head of the queue.

## Operation
- Input sampling: `cs` and `sclk` reset to 1. `mosi` resets to 0.
- Edge detection: a registered copy of each sampled signal provides the previous level. Edges are `cs_fall`, `cs_rise`, `sclk_rise` and `sclk_fall` on the sampled signals.
- SPI mode 0, MSB first:
  - mosi is captured on sclk rise.
  - miso is shifted on sclk fall.
- FSM state IDLE:
  - On `cs_fall`: load tx shift register from `to_master`, pulse `seize`, clear the bit counter, go to ACTIVE.
  - sclk edges are ignored.
- FSM state ACTIVE:
  - On `sclk_rise`: rx shift register becomes {rx[pack_size-2:0], mosi}. The bit counter increments and saturates at pack_size+1.
  - On `sclk_fall`: tx shift register shifts left by 1 and fills with 0.
  - On `cs_rise`: pulse `serve` and go to IDLE.
    - If bit count == pack_size: `from_master` <= rx and `hard_msg` = 0.
    - Otherwise `hard_msg` = 1 and `from_master` holds its previous value.
- Bit counter width is $clog2(pack_size)+1.
- `miso` = tx[pack_size-1]. It holds its value while IDLE.
- `cs` edges take precedence: a `cs_rise`/`cs_fall` in the same cycle as an sclk edge discards the sclk edge.
- `hard_msg` is valid only while `serve` = 1. It is 0 otherwise.
- `seize` fires every frame, whether or not the queue is empty. When the queue is empty, the transmitted word is the queue's stale head.
- Reset mid-frame:
  - All state clears and the FSM goes to IDLE.
  - If cs is held low at reset release, the sampled cs falls from its reset value of 1. That produces a `cs_fall`, and the partial frame terminates with `serve`=1, `hard_msg`=1.

## Timing
- Reset values: `miso`=0, `serve`=0, `hard_msg`=0, `seize`=0, `from_master`=0. FSM is in IDLE.
- `serve`, `hard_msg`, `seize` and `from_master` are registered outputs.
- Latency with the configuration macro defined: a pin change first sampled at clk edge k produces its registered action at edge k+3.
  - `seize`/`serve` are high during cycle k+3 only.
  - `miso` updates at edge k+3 after an sclk fall.
- Latency with the macro undefined: the same actions occur at edge k+2.
- clk must be at least 8x sclk, and cs must stay high for at least 4 clk cycles between frames.
- `to_master` is sampled at the same edge that `seize` rises. The queue advances its read pointer on that edge.

## Configuration
- `SPI_MINION_SHIFTER_SYNC_EN`.
- Defined: cs, sclk and mosi each pass through a two-flop synchronizer before edge detection.
- Undefined: a single sampling flop per pin, for benches that drive pins synchronously to clk. This removes one cycle of latency.

## Test plan
- Frame of 32 bits, 0xDEADBEEF MSB first, pack_size=32 -> one `serve` pulse with `hard_msg`=0 and `from_master`=0xDEADBEEF.
- Frame of 31 bits -> `serve`=1 with `hard_msg`=1, and `from_master` keeps its prior value.
- Frame of 33 bits -> `serve`=1 with `hard_msg`=1.
- `to_master`=0xA5A5_0F0F at cs fall -> `seize` pulses once. miso presents bits 1,0,1,0,0,1,0,1,... before each sclk rise, and 32 bits match 0xA5A50F0F.
- Two back-to-back frames, 0x00000001 then 0xFFFFFFFF, with 4-cycle cs-high gap -> two `seize`/`serve` pairs. `from_master` reads 0x00000001 and then 0xFFFFFFFF.
- `reset` asserted after 10 bits of a frame, then released with cs still low and 22 more bits clocked -> all outputs 0 during reset. On cs rise, `serve`=1 with `hard_msg`=1, and `from_master`=0.
